thd_sweep_controller: RTL and testbench

Sequencer for the THD measurement path: steps the sine generator through a programmable ladder of amplitudes, holds it in reset between levels, waits for the FIR filter output to settle, then streams a fixed-length window of filtered samples per level to a downstream logger. It sits between the sine generator's `amplitude`/`reset` inputs and the FIR filter's `data_out`, replacing open-loop bench sequencing with a synthesizable controller. An optional per-level peak detector reports the largest filtered magnitude in each window.

---
 rtl/thd_sweep_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_thd_sweep_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thd_sweep_controller.sv
// THD sweep sequencer: steps the sine generator through an amplitude ladder and streams
// one settled capture window per level. Optional per-level peak detector under THD_PEAK_EN.
module thd_sweep_controller #(
    parameter int          NUM_LEVELS    = 4,
    parameter logic [15:0] AMP_START     = 16'h1000,
    parameter logic [15:0] AMP_STEP      = 16'h1000,
    parameter int          SETTLE_CYCLES = 64,
    parameter int          CAPTURE_LEN   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [15:0]        amplitude,
    output logic               gen_rst,
    input  logic signed [31:0] filt_in,
    output logic signed [31:0] cap_data,
    output logic [7:0]         cap_level,
    output logic               cap_valid,
    output logic               cap_last,
    input  logic               cap_ready,
    output logic               overrun,
    output logic [31:0]        peak_abs,
    output logic               peak_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [7:0]  LAST_LEVEL   = 8'(NUM_LEVELS - 1);
    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] CAPTURE_LAST = 32'(CAPTURE_LEN - 1);

    state_t             state_r;
    state_t             state_s;
    state_t             base_next_s;
    logic [7:0]         level_r;
    logic [31:0]        cnt_r;
    logic [15:0]        amplitude_r;
    logic signed [31:0] cap_data_r;
    logic [7:0]         cap_level_r;
    logic               cap_valid_r;
    logic               cap_last_r;
    logic               overrun_r;
    logic               done_r;
    logic               abort_s;
    logic               load_s;
    logic               start_s;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign abort_s = abort && (state_r != ST_IDLE);
    assign start_s = (state_r == ST_IDLE) && start && !abort;
    assign load_s  = (state_r == ST_CAPTURE) && !abort;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; abort overrides every non-idle transition
    always_comb begin
        base_next_s = state_r;
        case (state_r)
            ST_IDLE:    base_next_s = start_s ? ST_LOAD : ST_IDLE;
            ST_LOAD:    base_next_s = ST_SETTLE;
            ST_SETTLE:  base_next_s = (cnt_r == 32'd0) ? ST_CAPTURE : ST_SETTLE;
            ST_CAPTURE: base_next_s = (cnt_r == 32'd0) ? ST_NEXT : ST_CAPTURE;
            ST_NEXT:    base_next_s = (level_r == LAST_LEVEL) ? ST_DONE : ST_LOAD;
            ST_DONE:    base_next_s = ST_IDLE;
            default:    base_next_s = ST_IDLE;
        endcase
        state_s = abort_s ? ST_IDLE : base_next_s;
    end

    // Phase counter, level index and amplitude ladder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= 32'd0;
            level_r     <= 8'd0;
            amplitude_r <= AMP_START;
        end else if (state_s == ST_IDLE) begin
            cnt_r       <= 32'd0;
            level_r     <= 8'd0;
            amplitude_r <= AMP_START;
        end else begin
            case (state_r)
                ST_LOAD:    cnt_r <= SETTLE_LAST;
                ST_SETTLE:  cnt_r <= (cnt_r == 32'd0) ? CAPTURE_LAST : cnt_r - 32'd1;
                ST_CAPTURE: cnt_r <= (cnt_r == 32'd0) ? 32'd0 : cnt_r - 32'd1;
                ST_NEXT: begin
                    if (level_r != LAST_LEVEL) begin
                        level_r     <= level_r + 8'd1;
                        amplitude_r <= sat_add16(amplitude_r, AMP_STEP);
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Capture output register: a fresh sample always wins over a pending one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_data_r  <= 32'sd0;
            cap_level_r <= 8'd0;
            cap_valid_r <= 1'b0;
            cap_last_r  <= 1'b0;
        end else if (abort_s) begin
            cap_valid_r <= 1'b0;
            cap_last_r  <= 1'b0;
        end else if (load_s) begin
            cap_data_r  <= filt_in;
            cap_level_r <= level_r;
            cap_valid_r <= 1'b1;
            cap_last_r  <= (cnt_r == 32'd0);
        end else if (cap_valid_r && cap_ready) begin
            cap_valid_r <= 1'b0;
            cap_last_r  <= 1'b0;
        end
    end

    // Sticky drop flag, cleared only by a new sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (start_s) begin
            overrun_r <= 1'b0;
        end else if (load_s && cap_valid_r && !cap_ready) begin
            overrun_r <= 1'b1;
        end
    end

    // Completion pulse, suppressed by abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == ST_DONE) && !abort;
        end
    end

`ifdef THD_PEAK_EN
    logic [31:0] peak_track_r;
    logic [31:0] peak_abs_r;
    logic        peak_valid_r;
    logic [31:0] mag_s;
    logic [31:0] peak_max_s;

    function automatic logic [31:0] abs_sat32(input logic signed [31:0] x);
        if (x == 32'sh8000_0000) begin
            return 32'h7FFF_FFFF;
        end else if (x < 32'sd0) begin
            return 32'(-x);
        end else begin
            return 32'(x);
        end
    endfunction

    assign mag_s      = abs_sat32(filt_in);
    assign peak_max_s = (mag_s > peak_track_r) ? mag_s : peak_track_r;

    // Window maximum, restarted as each capture window opens
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_track_r <= 32'd0;
        end else if ((state_r == ST_SETTLE) && (cnt_r == 32'd0)) begin
            peak_track_r <= 32'd0;
        end else if (load_s) begin
            peak_track_r <= peak_max_s;
        end
    end

    // Publish the window maximum on the final sample so it is visible during NEXT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_abs_r   <= 32'd0;
            peak_valid_r <= 1'b0;
        end else if (load_s && (cnt_r == 32'd0)) begin
            peak_abs_r   <= peak_max_s;
            peak_valid_r <= 1'b1;
        end else begin
            peak_valid_r <= 1'b0;
        end
    end

    assign peak_abs   = peak_abs_r;
    assign peak_valid = peak_valid_r;
`else
    assign peak_abs   = 32'd0;
    assign peak_valid = 1'b0;
`endif

    assign amplitude = amplitude_r;
    assign gen_rst   = (state_r != ST_SETTLE) && (state_r != ST_CAPTURE);
    assign cap_data  = cap_data_r;
    assign cap_level = cap_level_r;
    assign cap_valid = cap_valid_r;
    assign cap_last  = cap_last_r;
    assign overrun   = overrun_r;
    assign busy      = (state_r != ST_IDLE);
    assign done      = done_r;

endmodule

// File: tb/tb_thd_sweep_controller.sv
// Directed bench for thd_sweep_controller: default-size sweep plus a small-window instance
// used for cycle-exact timing, saturation, overrun/abort, peak and async reset checks.
module tb_thd_sweep_controller;

`ifdef THD_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic               start_d, abort_d, ready_d;
    logic signed [31:0] filt_d;
    logic [15:0]        amp_d;
    logic               gen_rst_d, cap_valid_d, cap_last_d, overrun_d, peak_valid_d, busy_d, done_d;
    logic signed [31:0] cap_data_d;
    logic [7:0]         cap_level_d;
    logic [31:0]        peak_abs_d;

    logic               start_m, abort_m, ready_m;
    logic signed [31:0] filt_m;
    logic [15:0]        amp_m;
    logic               gen_rst_m, cap_valid_m, cap_last_m, overrun_m, peak_valid_m, busy_m, done_m;
    logic signed [31:0] cap_data_m;
    logic [7:0]         cap_level_m;
    logic [31:0]        peak_abs_m;

    thd_sweep_controller u_def (
        .clk(clk), .rst(rst), .start(start_d), .abort(abort_d),
        .amplitude(amp_d), .gen_rst(gen_rst_d), .filt_in(filt_d),
        .cap_data(cap_data_d), .cap_level(cap_level_d), .cap_valid(cap_valid_d),
        .cap_last(cap_last_d), .cap_ready(ready_d), .overrun(overrun_d),
        .peak_abs(peak_abs_d), .peak_valid(peak_valid_d), .busy(busy_d), .done(done_d)
    );

    thd_sweep_controller #(
        .NUM_LEVELS(3), .AMP_START(16'hF000), .AMP_STEP(16'h2000),
        .SETTLE_CYCLES(3), .CAPTURE_LEN(4)
    ) u_mini (
        .clk(clk), .rst(rst), .start(start_m), .abort(abort_m),
        .amplitude(amp_m), .gen_rst(gen_rst_m), .filt_in(filt_m),
        .cap_data(cap_data_m), .cap_level(cap_level_m), .cap_valid(cap_valid_m),
        .cap_last(cap_last_m), .cap_ready(ready_m), .overrun(overrun_m),
        .peak_abs(peak_abs_m), .peak_valid(peak_valid_m), .busy(busy_m), .done(done_m)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          samples, bad, last_cnt, first_n, done_cnt, done_n, busy_seen, exp_lvl;
    int          j, o;
    logic        exp_valid, exp_pv;
    logic [31:0] peak_exp;
    logic [15:0] amp_tab [3];

    initial begin
        amp_tab[0] = 16'hF000;
        amp_tab[1] = 16'hFFFF;
        amp_tab[2] = 16'hFFFF;
        rst = 1'b1;
        start_d = 1'b0; abort_d = 1'b0; ready_d = 1'b1; filt_d = 32'sd0;
        start_m = 1'b0; abort_m = 1'b0; ready_m = 1'b1; filt_m = 32'sd0;
        repeat (3) tick();

        // Reset values
        check("rst_amp", 32'(amp_d), 32'h1000);
        check("rst_amp_mini", 32'(amp_m), 32'hF000);
        check("rst_gen_rst", 32'(gen_rst_d), 32'd1);
        check("rst_cap_valid", 32'(cap_valid_d), 32'd0);
        check("rst_cap_data", 32'(cap_data_d), 32'd0);
        check("rst_overrun", 32'(overrun_d), 32'd0);
        check("rst_peak_abs", peak_abs_d, 32'd0);
        check("rst_busy", 32'(busy_d), 32'd0);
        check("rst_done", 32'(done_d), 32'd0);
        rst = 1'b0;
        tick();

        // Full default sweep with an always-ready logger
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        check("def_busy_k", 32'(busy_d), 32'd1);
        check("def_gen_rst_k", 32'(gen_rst_d), 32'd1);
        tick();
        check("def_gen_rst_k1", 32'(gen_rst_d), 32'd0);
        samples = 0; bad = 0; last_cnt = 0; first_n = -1; done_cnt = 0; done_n = -1;
        for (int n = 2; n <= 4400; n++) begin
            tick();
            if (cap_valid_d) begin
                samples++;
                exp_lvl = (samples - 1) / 1024;
                if (first_n < 0) first_n = n;
                if (cap_level_d !== 8'(exp_lvl)) bad++;
                if (amp_d !== 16'(4096 * (exp_lvl + 1))) bad++;
                if (cap_last_d !== ((samples % 1024) == 0)) bad++;
                if (cap_last_d) last_cnt++;
            end
            if (done_d) begin
                done_cnt++;
                done_n = n;
            end
        end
        check("def_samples", 32'(samples), 32'd4096);
        check("def_first_valid", 32'(first_n), 32'd66);
        check("def_level_amp_last", 32'(bad), 32'd0);
        check("def_last_count", 32'(last_cnt), 32'd4);
        check("def_done_count", 32'(done_cnt), 32'd1);
        check("def_done_cycle", 32'(done_n), 32'd4361);
        check("def_overrun", 32'(overrun_d), 32'd0);
        check("def_idle_busy", 32'(busy_d), 32'd0);

        // Small instance: cycle-exact sweep with filt_in = cycle index
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        check("mini_gen_rst_k", 32'(gen_rst_m), 32'd1);
        peak_exp = 32'd0;
        for (int n = 1; n <= 32; n++) begin
            filt_m = 32'(n);
            tick();
            j = (n / 9 > 2) ? 2 : n / 9;
            o = n % 9;
            exp_valid = (o >= 5) && (n <= 26);
            exp_pv    = PEAK_ON && (o == 8) && (n <= 26);
            if (exp_pv) peak_exp = 32'(n);
            check("mini_valid", 32'(cap_valid_m), 32'(exp_valid));
            check("mini_last", 32'(cap_last_m), 32'(exp_valid && (o == 8)));
            check("mini_gen_rst", 32'(gen_rst_m), 32'(!((n < 27) && (o >= 1) && (o <= 7))));
            check("mini_busy", 32'(busy_m), 32'(n <= 27));
            check("mini_done", 32'(done_m), 32'(n == 28));
            check("mini_amp", 32'(amp_m), (n <= 27) ? 32'(amp_tab[j]) : 32'hF000);
            check("mini_peak_valid", 32'(peak_valid_m), 32'(exp_pv));
            check("mini_peak_abs", peak_abs_m, peak_exp);
            if (exp_valid) begin
                check("mini_data", 32'(cap_data_m), 32'(n));
                check("mini_level", 32'(cap_level_m), 32'(j));
            end
        end

        // Overrun while logger stalls, then abort in level 1
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int i = 0; i < 200 && !cap_valid_d; i++) tick();
        check("ovr_first_valid", 32'(cap_valid_d), 32'd1);
        ready_d = 1'b0;
        repeat (10) tick();
        check("ovr_set", 32'(overrun_d), 32'd1);
        check("ovr_valid_held", 32'(cap_valid_d), 32'd1);
        ready_d = 1'b1;
        repeat (5) tick();
        check("ovr_sticky", 32'(overrun_d), 32'd1);
        for (int i = 0; i < 2200 && !(cap_valid_d && cap_level_d == 8'd1); i++) tick();
        check("abort_reach_lvl1", 32'(cap_level_d), 32'd1);
        repeat (3) tick();
        abort_d = 1'b1;
        tick();
        abort_d = 1'b0;
        check("abort_busy", 32'(busy_d), 32'd0);
        check("abort_gen_rst", 32'(gen_rst_d), 32'd1);
        check("abort_cap_valid", 32'(cap_valid_d), 32'd0);
        check("abort_overrun_kept", 32'(overrun_d), 32'd1);
        check("abort_amp", 32'(amp_d), 32'h1000);
        done_cnt = 0; busy_seen = 0;
        repeat (20) begin
            tick();
            if (done_d) done_cnt++;
            if (busy_d) busy_seen++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_stays_idle", 32'(busy_seen), 32'd0);
        start_d = 1'b1;
        abort_d = 1'b1;
        tick();
        start_d = 1'b0;
        abort_d = 1'b0;
        check("abort_beats_start", 32'(busy_d), 32'd0);
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        check("restart_clears_ovr", 32'(overrun_d), 32'd0);
        check("restart_busy", 32'(busy_d), 32'd1);
        abort_d = 1'b1;
        tick();
        abort_d = 1'b0;
        check("restart_abort_idle", 32'(busy_d), 32'd0);

        // Peak magnitude with the most-negative sample, then async reset mid-capture
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            case (n)
                5:       filt_m = 32'sd5;
                6:       filt_m = 32'sh8000_0000;
                7:       filt_m = 32'sd7;
                8:       filt_m = -32'sd3;
                default: filt_m = 32'sd0;
            endcase
            tick();
            if (n == 6) check("pk_min_sample", 32'(cap_data_m), 32'h8000_0000);
            if (n == 8) begin
                check("pk_valid", 32'(peak_valid_m), 32'(PEAK_ON));
                check("pk_abs", peak_abs_m, PEAK_ON ? 32'h7FFF_FFFF : 32'd0);
            end
            if (n == 9) check("pk_single_pulse", 32'(peak_valid_m), 32'd0);
        end
        check("arst_pre_valid", 32'(cap_valid_m), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_amp", 32'(amp_m), 32'hF000);
        check("arst_gen_rst", 32'(gen_rst_m), 32'd1);
        check("arst_cap_data", 32'(cap_data_m), 32'd0);
        check("arst_cap_level", 32'(cap_level_m), 32'd0);
        check("arst_cap_valid", 32'(cap_valid_m), 32'd0);
        check("arst_cap_last", 32'(cap_last_m), 32'd0);
        check("arst_overrun", 32'(overrun_m), 32'd0);
        check("arst_peak_abs", peak_abs_m, 32'd0);
        check("arst_peak_valid", 32'(peak_valid_m), 32'd0);
        check("arst_busy", 32'(busy_m), 32'd0);
        check("arst_done", 32'(done_m), 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_after_busy", 32'(busy_m), 32'd0);
        check("arst_after_done", 32'(done_m), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
